cache_arbiter_rr: RTL and testbench
===================================

Name: cache_arbiter_rr

Overview:
N-channel arbiter between NUM_PORTS L1 caches (I, D, prefetch, ...) and one shared L2 port. It is the parametrised successor of the fixed two-port I/D arbiter datapath. It adds an integrated control FSM, round-robin fairness, and write support on every channel. All L2-facing address and data are registered (MAR/MDR style), and the L2 read data is registered and broadcast to all clients.

Parameters:
NUM_PORTS, 2, number of L1 clients (2..8); port 0 has highest priority after reset.
ADDR_W, 16, address width (lc3b_word).
LINE_W, 128, cache-line width (lc3b_l1_line).

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
client_address  in  NUM_PORTS*ADDR_W  per-client line address; client i occupies bits [i*ADDR_W +: ADDR_W]
client_wdata  in  NUM_PORTS*LINE_W  per-client write line; same packing rule
client_read  in  NUM_PORTS  per-client read request, held until that client's resp
client_write  in  NUM_PORTS  per-client write request, held until that client's resp
client_rdata  out  LINE_W  registered L2 read line, common to all clients
client_resp  out  NUM_PORTS  one-cycle completion pulse, one-hot
l2_address  out  ADDR_W  registered address to L2
l2_wdata  out  LINE_W  registered write line to L2
l2_read  out  1  L2 read strobe, held until l2_resp
l2_write  out  1  L2 write strobe, held until l2_resp
l2_rdata  in  LINE_W  L2 read line, valid while l2_resp is high
l2_resp  in  1  L2 completion, one cycle
grant_id  out  $clog2(NUM_PORTS)  index of the currently or last granted client
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; rr_ptr=0; grant_id=0.
  - l2_read, l2_write, client_resp and busy are all 0.
  - l2_address, l2_wdata and client_rdata are all 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - A client is requesting when client_read[i] | client_write[i].
  - Select the first requesting client scanning i = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_PORTS.
  - On selection, in the same edge: load l2_address and l2_wdata from that client; set grant_id; latch op (write wins if both read and write are high); go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - l2_read or l2_write is driven from the latched op, combinationally from state; exactly one is high.
  - Client inputs are ignored; dropping a request mid-transaction has no effect.
  - l2_resp=1: capture l2_rdata into client_rdata (reads only; writes leave it unchanged); go to RESP.
  - l2_resp=0: stay in ISSUE, with no timeout.
- RESP:
  - client_resp[grant_id]=1 for exactly one cycle.
  - rr_ptr <= (grant_id+1) mod NUM_PORTS; go to IDLE unconditionally.
- Latency:
  - The request is sampled in IDLE at cycle 0.
  - l2_read or l2_write is high from cycle 1.
  - l2_resp arrives at cycle k≥1.
  - client_resp is high at cycle k+1.
  - Minimum round trip is 2 cycles (l2_resp on the first ISSUE cycle), with 1 idle cycle between back-to-back grants.
- Clients deassert their request on the edge after their resp; the IDLE cycle after RESP therefore never regrants a completed request.
- client_rdata holds its value until the next read completion.
- Simultaneous requests:
  - Strict rotation from rr_ptr, so any client is served within NUM_PORTS grants.
  - Requests that arrive during ISSUE or RESP wait for IDLE.
- l2_resp outside ISSUE is ignored.
- Reset asserted mid-transaction: the strobes drop immediately; the pending client gets no resp.
- NUM_PORTS=1: rr_ptr stays 0; grant_id is a 1-bit constant 0.

Decomposition:
- lc3b_types gains arb_state_t (IDLE/ISSUE/RESP) and arb_op_t (ARB_READ/ARB_WRITE).
- Line and word widths reuse lc3b_l1_line and lc3b_word as the parameter defaults.
- One sub-module, rr_priority_select: inputs req[NUM_PORTS] and ptr; outputs valid and idx.
  - Purely combinational rotate-then-priority-encode.
  - Reusable by the future L2-to-memory arbiter.
- Registers use the existing register module with the load enables derived in this block.

Test Plan:
1. Single read, NUM_PORTS=2: client 0 reads 0x1230, L2 answers after 3 cycles with line 0xA5..A5.
   -> l2_read high for 3 cycles with l2_address=0x1230; client_resp=2'b01 for one cycle; client_rdata=0xA5..A5; client_resp[1] stays 0.
2. Write, client 1 at 0x4440 with wdata 0x0F..0F.
   -> l2_write=1, l2_wdata=0x0F..0F, client_rdata unchanged, client_resp=2'b10, grant_id=1.
3. Contention, NUM_PORTS=4: all four request continuously after reset.
   -> grant order 0,1,2,3,0; each client_resp one-hot exactly once per four grants.
4. Read and write both high on client 2.
   -> only l2_write asserts; exactly one client_resp[2] pulse.
5. Reset during ISSUE (l2_read=1): pull reset_n low with no clock edge.
   -> l2_read=0 and busy=0 immediately; after release, client 1's pending request is granted first (rr_ptr=0 scan, client 0 idle).
6. Stray l2_resp pulses in IDLE and RESP.
   -> no state change; client_rdata is not loaded.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: line/word widths and arbiter enums.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_l1_line;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Operation latched at grant time.
  typedef enum logic {
    ARB_READ  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_op_t;

  // Width of a client index; a single client still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin selector: rotate the request vector so that ptr sits at bit 0,
// isolate the lowest set bit, encode it and add ptr back modulo NUM_PORTS.
// Purely combinational.
module rr_priority_select
  import lc3b_types::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]                 req,
  input  logic [idx_width(NUM_PORTS)-1:0]      ptr,
  output logic                                 valid,
  output logic [idx_width(NUM_PORTS)-1:0]      idx
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam logic [IDX_W:0] NUM_P = (IDX_W+1)'(NUM_PORTS);

  logic [NUM_PORTS-1:0] rot;
  logic [NUM_PORTS-1:0] first;
  logic [IDX_W-1:0]     off;
  logic [IDX_W:0]       sum;

  // Doubling the vector makes the right shift a rotation.
  assign rot   = NUM_PORTS'({req, req} >> ptr);
  assign first = rot & (~rot + NUM_PORTS'(1));

  // One-hot to binary: offset bit gi is the OR of all one-hot bits whose
  // position has bit gi set.
  genvar gi, gk;
  generate
    for (gi = 0; gi < IDX_W; gi++) begin : g_bit
      logic [NUM_PORTS-1:0] hit;
      for (gk = 0; gk < NUM_PORTS; gk++) begin : g_port
        if (((gk >> gi) & 1) != 0) begin : g_on
          assign hit[gk] = first[gk];
        end else begin : g_off
          assign hit[gk] = 1'b0;
        end
      end
      assign off[gi] = |hit;
    end
  endgenerate

  assign sum   = {1'b0, ptr} + {1'b0, off};
  assign idx   = (sum >= NUM_P) ? IDX_W'(sum - NUM_P) : IDX_W'(sum);
  assign valid = |req;

endmodule

// File: rtl/cache_arbiter_rr.sv
// Round-robin arbiter from NUM_PORTS L1 clients to one shared L2 port.
// Address/write data are captured at grant time; L2 read data is captured
// on completion and broadcast to every client.
module cache_arbiter_rr
  import lc3b_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = $bits(lc3b_word),
  parameter int LINE_W    = $bits(lc3b_l1_line)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_PORTS*ADDR_W-1:0]       client_address,
  input  logic [NUM_PORTS*LINE_W-1:0]       client_wdata,
  input  logic [NUM_PORTS-1:0]              client_read,
  input  logic [NUM_PORTS-1:0]              client_write,
  output logic [LINE_W-1:0]                 client_rdata,
  output logic [NUM_PORTS-1:0]              client_resp,
  output logic [ADDR_W-1:0]                 l2_address,
  output logic [LINE_W-1:0]                 l2_wdata,
  output logic                              l2_read,
  output logic                              l2_write,
  input  logic [LINE_W-1:0]                 l2_rdata,
  input  logic                              l2_resp,
  output logic [idx_width(NUM_PORTS)-1:0]   grant_id,
  output logic                              busy
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam logic [IDX_W:0] NUM_P = (IDX_W+1)'(NUM_PORTS);

  arb_state_t        state_q;
  arb_op_t           op_q;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  rr_ptr_d;
  logic [IDX_W:0]    grant_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;

  logic [NUM_PORTS-1:0] req;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;
  arb_op_t              sel_op;
  logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
  logic [LINE_W-1:0]    wdata_arr [NUM_PORTS];

  logic load_grant;
  logic load_rdata;

  // Unpack the per-client buses so the granted client can be indexed.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_client
      assign addr_arr[gi]    = client_address[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]   = client_wdata[gi*LINE_W +: LINE_W];
      assign client_resp[gi] = (state_q == RESP) && (grant_q == IDX_W'(gi));
    end
  endgenerate

  assign req = client_read | client_write;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_select (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  // A client raising both strobes is treated as a write.
  assign sel_op = client_write[sel_idx] ? ARB_WRITE : ARB_READ;

  assign load_grant = (state_q == IDLE) && sel_valid;
  assign load_rdata = (state_q == ISSUE) && l2_resp && (op_q == ARB_READ);

  // Pointer moves to the client after the one just served, modulo NUM_PORTS.
  assign grant_inc = {1'b0, grant_q} + (IDX_W+1)'(1);
  assign rr_ptr_d  = (grant_inc == NUM_P) ? '0 : IDX_W'(grant_inc);

  // Control FSM: grant in IDLE, wait for L2 in ISSUE, pulse resp in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= ARB_READ;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            grant_q <= sel_idx;
            op_q    <= sel_op;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (l2_resp) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // L2-facing address/data registers and the broadcast read-line register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (load_grant) begin
        addr_q  <= addr_arr[sel_idx];
        wdata_q <= wdata_arr[sel_idx];
      end
      if (load_rdata) begin
        rdata_q <= l2_rdata;
      end
    end
  end

  assign l2_read      = (state_q == ISSUE) && (op_q == ARB_READ);
  assign l2_write     = (state_q == ISSUE) && (op_q == ARB_WRITE);
  assign l2_address   = addr_q;
  assign l2_wdata     = wdata_q;
  assign client_rdata = rdata_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cache_arbiter_rr.sv
// Randomized bench for cache_arbiter_rr with four clients. A behavioural
// model tracks which client should be served next (scan from the pointer
// with modulo arithmetic) and what every output should show each cycle.
module tb_cache_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N*AW-1:0] client_address;
  logic [N*LW-1:0] client_wdata;
  logic [N-1:0]  client_read;
  logic [N-1:0]  client_write;
  logic [LW-1:0] client_rdata;
  logic [N-1:0]  client_resp;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic          l2_read;
  logic          l2_write;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;
  logic [IW-1:0] grant_id;
  logic          busy;

  always #5 clk = ~clk;

  cache_arbiter_rr #(
    .NUM_PORTS (N),
    .ADDR_W    (AW),
    .LINE_W    (LW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .client_address (client_address),
    .client_wdata   (client_wdata),
    .client_read    (client_read),
    .client_write   (client_write),
    .client_rdata   (client_rdata),
    .client_resp    (client_resp),
    .l2_address     (l2_address),
    .l2_wdata       (l2_wdata),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_rdata       (l2_rdata),
    .l2_resp        (l2_resp),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Client-side state as seen by the bench.
  bit            c_rd    [N];
  bit            c_wr    [N];
  logic [AW-1:0] c_addr  [N];
  logic [LW-1:0] c_wdata [N];

  // Behavioural model: phase 0 = idle, 1 = waiting on L2, 2 = completion.
  int            m_phase;
  int            m_grant;
  int            m_ptr;
  bit            m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic [LW-1:0] m_rdata;

  task automatic drive_ports();
    for (int i = 0; i < N; i++) begin
      client_address[i*AW +: AW] = c_addr[i];
      client_wdata[i*LW +: LW]   = c_wdata[i];
      client_read[i]             = c_rd[i];
      client_write[i]            = c_wr[i];
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_grant = 0;
    m_ptr   = 0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
  endtask

  initial begin
    int  done_cnt;
    int  found;
    int  cand;
    bit  contention;
    bit  rst_armed;
    logic [N-1:0] exp_resp;

    done_cnt  = 0;
    rst_armed = 1'b0;
    for (int i = 0; i < N; i++) begin
      c_rd[i]    = 1'b0;
      c_wr[i]    = 1'b0;
      c_addr[i]  = AW'($urandom());
      c_wdata[i] = rand_line();
    end
    l2_resp  = 1'b0;
    l2_rdata = rand_line();
    drive_ports();

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy",     busy, '0);
    check_val("rst_l2_read",  l2_read, '0);
    check_val("rst_l2_write", l2_write, '0);
    check_val("rst_resp",     client_resp, '0);
    check_val("rst_grant",    grant_id, '0);
    check_val("rst_l2_addr",  l2_address, '0);
    check_val("rst_l2_wdata", l2_wdata, '0);
    check_val("rst_rdata",    client_rdata, '0);
    reset_n = 1'b1;
    model_reset();

    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      if (cyc == 700 || cyc == 1600) rst_armed = 1'b1;
      contention = (cyc >= 200 && cyc < 500);

      // Compare outputs against the model's view of the current state.
      exp_resp = '0;
      if (m_phase == 2) exp_resp[m_grant] = 1'b1;
      check_val("busy",     busy, LW'(m_phase != 0));
      check_val("l2_read",  l2_read, LW'(m_phase == 1 && !m_write));
      check_val("l2_write", l2_write, LW'(m_phase == 1 && m_write));
      check_val("resp",     client_resp, exp_resp);
      check_val("grant_id", grant_id, LW'(m_grant));
      check_val("rdata",    client_rdata, m_rdata);
      if (m_phase == 1) begin
        check_val("l2_addr",  l2_address, m_addr);
        check_val("l2_wdata", l2_wdata, m_wdata);
      end

      // Completed client drops its request.
      if (m_phase == 2) begin
        done_cnt++;
        $display("txn %0d port=%0d op=%s addr=%h", done_cnt, m_grant,
                 m_write ? "WR" : "RD", m_addr);
        c_rd[m_grant] = 1'b0;
        c_wr[m_grant] = 1'b0;
      end

      // Asynchronous reset while the L2 strobe is up: strobes must drop
      // without a clock edge; the pending client keeps requesting.
      if (rst_armed && m_phase == 1) begin
        rst_armed = 1'b0;
        l2_resp = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_val("async_rst_l2_read",  l2_read, '0);
        check_val("async_rst_l2_write", l2_write, '0);
        check_val("async_rst_busy",     busy, '0);
        check_val("async_rst_resp",     client_resp, '0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        $display("reset applied mid-transaction at cycle %0d", cyc);
      end

      // New requests for idle clients.
      for (int i = 0; i < N; i++) begin
        if (!(c_rd[i] || c_wr[i])) begin
          if (contention || $urandom_range(0, 3) == 0) begin
            c_addr[i]  = AW'($urandom());
            c_wdata[i] = rand_line();
            case ($urandom_range(0, 2))
              0:       begin c_rd[i] = 1'b1; c_wr[i] = 1'b0; end
              1:       begin c_rd[i] = 1'b0; c_wr[i] = 1'b1; end
              default: begin c_rd[i] = 1'b1; c_wr[i] = 1'b1; end
            endcase
          end
        end
      end

      // Granted client changes its inputs mid-transaction; must be ignored.
      if (m_phase == 1 && $urandom_range(0, 3) == 0) begin
        c_addr[m_grant]  = AW'($urandom());
        c_wdata[m_grant] = rand_line();
      end

      // L2 side: real responses while waiting, stray pulses otherwise.
      l2_rdata = rand_line();
      if (m_phase == 1) l2_resp = ($urandom_range(0, 2) == 0);
      else              l2_resp = ($urandom_range(0, 4) == 0);
      drive_ports();

      // Advance the model to what the next rising edge should produce.
      case (m_phase)
        0: begin
          found = -1;
          for (int k = 0; k < N; k++) begin
            cand = (m_ptr + k) % N;
            if (found < 0 && (c_rd[cand] || c_wr[cand])) found = cand;
          end
          if (found >= 0) begin
            m_grant = found;
            m_addr  = c_addr[found];
            m_wdata = c_wdata[found];
            m_write = c_wr[found];
            m_phase = 1;
          end
        end
        1: begin
          if (l2_resp) begin
            if (!m_write) m_rdata = l2_rdata;
            m_phase = 2;
          end
        end
        default: begin
          m_ptr   = (m_grant + 1) % N;
          m_phase = 0;
        end
      endcase
    end

    check_val("enough_txns", LW'(done_cnt > 100), LW'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
